// File: rtl/mpu6050_frame_unpacker.sv
// Unpacks the 14-byte MPU-6050 burst (0x3B..0x48) into signed sample words with a valid/ready handshake.
// Optional gyro bias calibration is enabled by defining MPU6050_GYRO_CALIB_EN.
module mpu6050_frame_unpacker #(
    parameter int FRAME_BYTES = 14,
    parameter int ERR_CNT_W   = 8,
    parameter int CALIB_LOG2  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 frame_end,
    output logic signed [15:0]   accel_x,
    output logic signed [15:0]   accel_y,
    output logic signed [15:0]   accel_z,
    output logic signed [15:0]   temp,
    output logic signed [15:0]   gyro_x,
    output logic signed [15:0]   gyro_y,
    output logic signed [15:0]   gyro_z,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 calib_done
);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT, DISCARD} state_t;

    localparam logic [3:0] LAST = 4'(FRAME_BYTES);

    state_t             state;
    logic [3:0]         cnt;
    logic [3:0]         cnt_upd;
    logic [3:0]         store_idx;
    logic               store_en;
    logic               overflow;
    logic               err_hit;
    logic               load;
    logic [7:0]         shadow [FRAME_BYTES];
    logic signed [15:0] word [7];
    logic signed [15:0] gyro_adj [3];

    always_comb begin
        overflow  = byte_valid && (state == COLLECT) && (cnt == LAST);
        store_en  = byte_valid && ((state == IDLE) || ((state == COLLECT) && !overflow));
        store_idx = (state == IDLE) ? 4'd0 : cnt;
        cnt_upd   = cnt + {3'b000, byte_valid};
        // A byte arriving with frame_end is counted before the length check.
        err_hit   = ((state == IDLE) && byte_valid && frame_end)
                 || overflow
                 || ((state == COLLECT) && !overflow && frame_end && (cnt_upd != LAST));
        for (int i = 0; i < 7; i++) begin
            word[i] = {shadow[2*i], shadow[2*i+1]};
        end
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            shadow[store_idx] <= byte_data;
        end
    end

`ifdef MPU6050_GYRO_CALIB_EN
    localparam int ACC_W = 16 + CALIB_LOG2;

    logic signed [ACC_W-1:0] acc [3];
    logic signed [ACC_W-1:0] bias [3];
    logic signed [ACC_W:0]   diff [3];
    logic [CALIB_LOG2-1:0]   cal_cnt;
    logic                    cal_done;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W:0] v);
        if (v > $signed((ACC_W+1)'(32767))) begin
            return 16'sh7fff;
        end else if (v < -$signed((ACC_W+1)'(32768))) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bias[i]     = acc[i] >>> CALIB_LOG2;
            diff[i]     = (ACC_W+1)'(word[4+i]) - (ACC_W+1)'(bias[i]);
            gyro_adj[i] = sat16(diff[i]);
        end
        load = (state == COMMIT) && cal_done;
    end

    // Frames committed before calibration completes only feed the bias accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                acc[i] <= '0;
            end
            cal_cnt  <= '0;
            cal_done <= 1'b0;
        end else if ((state == COMMIT) && !cal_done) begin
            for (int i = 0; i < 3; i++) begin
                acc[i] <= acc[i] + ACC_W'(word[4+i]);
            end
            cal_cnt <= cal_cnt + 1'b1;
            if (cal_cnt == '1) begin
                cal_done <= 1'b1;
            end
        end
    end

    assign calib_done = cal_done;
`else
    logic [CALIB_LOG2-1:0] unused_calib;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            gyro_adj[i] = word[4+i];
        end
        load = (state == COMMIT);
    end

    assign unused_calib = '0;
    assign calib_done   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            err_cnt      <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            accel_x      <= '0;
            accel_y      <= '0;
            accel_z      <= '0;
            temp         <= '0;
            gyro_x       <= '0;
            gyro_y       <= '0;
            gyro_z       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        if (frame_end) begin
                            cnt <= 4'd0;
                        end else begin
                            cnt   <= 4'd1;
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (overflow) begin
                        cnt   <= 4'd0;
                        state <= frame_end ? IDLE : DISCARD;
                    end else if (frame_end) begin
                        cnt   <= 4'd0;
                        state <= (cnt_upd == LAST) ? COMMIT : IDLE;
                    end else begin
                        cnt <= cnt_upd;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                DISCARD: begin
                    if (frame_end) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase

            if (err_hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end

            // Output registers hold one sample; a new commit replaces it even if unaccepted.
            if (load) begin
                accel_x      <= word[0];
                accel_y      <= word[1];
                accel_z      <= word[2];
                temp         <= word[3];
                gyro_x       <= gyro_adj[0];
                gyro_y       <= gyro_adj[1];
                gyro_z       <= gyro_adj[2];
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mpu6050_frame_unpacker.sv
// Scoreboard bench for mpu6050_frame_unpacker: good, short, long, overlapped and back-pressured frames.
module tb_mpu6050_frame_unpacker;

    typedef struct packed {
        logic [15:0] ax, ay, az, t, gx, gy, gz;
    } sample_t;

`ifdef MPU6050_GYRO_CALIB_EN
    localparam logic CAL = 1'b1;
`else
    localparam logic CAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        frame_end = 1'b0;
    logic        sample_ready = 1'b1;
    logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
    logic        sample_valid, overrun, calib_done;
    logic [7:0]  err_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    sample_t     sb[$];
    sample_t     last_exp;
    sample_t     mon_e;
    logic signed [15:0] bias = 16'sh0000;

    mpu6050_frame_unpacker #(
        .FRAME_BYTES (14),
        .ERR_CNT_W   (8),
        .CALIB_LOG2  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .frame_end    (frame_end),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .temp         (temp),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .err_cnt      (err_cnt),
        .calib_done   (calib_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_gyro(input logic [15:0] raw);
        int d;
        if (!CAL) return raw;
        d = int'($signed(raw)) - int'(bias);
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        return d[15:0];
    endfunction

    function automatic sample_t expect_of(input sample_t s);
        sample_t e;
        e    = s;
        e.gx = exp_gyro(s.gx);
        e.gy = exp_gyro(s.gy);
        e.gz = exp_gyro(s.gz);
        return e;
    endfunction

    function automatic sample_t rand_sample();
        sample_t s;
        s.ax = 16'($urandom); s.ay = 16'($urandom); s.az = 16'($urandom);
        s.t  = 16'($urandom); s.gx = 16'($urandom_range(0, 16'h3fff));
        s.gy = 16'($urandom); s.gz = 16'($urandom);
        return s;
    endfunction

    // Compare every accepted sample against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            check("sb_empty_on_sample", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("ax", accel_x, mon_e.ax);
                check("ay", accel_y, mon_e.ay);
                check("az", accel_z, mon_e.az);
                check("t",  temp,    mon_e.t);
                check("gx", gyro_x,  mon_e.gx);
                check("gy", gyro_y,  mon_e.gy);
                check("gz", gyro_z,  mon_e.gz);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bytes(input sample_t s, input int n);
        logic [111:0] bits;
        bits = s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            byte_valid = 1'b1;
            byte_data  = (i < 14) ? bits[111-8*i -: 8] : 8'hA5;
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_end();
        @(posedge clk); #1 frame_end = 1'b1;
        @(posedge clk); #1 frame_end = 1'b0;
    endtask

    task automatic send_good(input sample_t s);
        last_exp = expect_of(s);
        sb.push_back(last_exp);
        send_bytes(s, 14);
        pulse_end();
        idle(4);
    endtask

    task automatic calibrate();
        sample_t s;
        @(negedge clk);
        check("calib_pending", calib_done, 1'b0);
        for (int k = 0; k < 4; k++) begin
            s = rand_sample();
            s.gx = 16'h0010; s.gy = 16'h0010; s.gz = 16'h0010;
            send_bytes(s, 14);
            pulse_end();
            idle(3);
        end
        bias = 16'sh0010;
        @(negedge clk);
        check("calib_done", calib_done, 1'b1);
        check("calib_no_valid", sample_valid, 1'b0);
    endtask

    initial begin
        sample_t s;
        sample_t a;
        sample_t b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_ax", accel_x, 16'h0000);
        check("rst_gz", gyro_z, 16'h0000);
        check("rst_err", err_cnt, 8'd0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_calib", calib_done, !CAL);
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        if (CAL) begin
            calibrate();
            s = rand_sample(); s.gx = 16'h8005; send_good(s);
            s = rand_sample(); s.gx = 16'h0020; send_good(s);
        end

        // Basic frame with cycle-exact latency.
        s = {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E};
        last_exp = expect_of(s);
        sb.push_back(last_exp);
        send_bytes(s, 14);
        @(posedge clk); #1 frame_end = 1'b1;
        @(negedge clk);
        check("lat_end", sample_valid, 1'b0);
        @(posedge clk); #1 frame_end = 1'b0;
        @(negedge clk);
        check("lat_commit", sample_valid, 1'b0);
        @(negedge clk);
        check("lat_valid", sample_valid, 1'b1);
        check("basic_ax", accel_x, 16'h0102);
        check("basic_t", temp, 16'h0708);
        check("basic_gz", gyro_z, exp_gyro(16'h0D0E));
        @(negedge clk);
        check("basic_drop", sample_valid, 1'b0);
        check("basic_err", err_cnt, 8'd0);
        check("basic_ovr", overrun, 1'b0);

        // Short frame.
        send_bytes(rand_sample(), 13);
        pulse_end();
        idle(3);
        @(negedge clk);
        check("short_err", err_cnt, 8'd1);
        check("short_valid", sample_valid, 1'b0);
        send_good(rand_sample());

        // Long frame leaves outputs alone.
        send_bytes(rand_sample(), 15);
        pulse_end();
        idle(3);
        @(negedge clk);
        check("long_err", err_cnt, 8'd2);
        check("long_valid", sample_valid, 1'b0);
        check("long_ax_kept", accel_x, last_exp.ax);
        send_good(rand_sample());

        // Last byte coincides with frame_end.
        s = rand_sample();
        last_exp = expect_of(s);
        sb.push_back(last_exp);
        send_bytes(s, 13);
        @(posedge clk); #1;
        byte_valid = 1'b1; byte_data = s.gz[7:0]; frame_end = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0; frame_end = 1'b0;
        idle(4);
        @(negedge clk);
        check("same_cycle_err", err_cnt, 8'd2);

        // Frame end with no bytes is ignored.
        pulse_end();
        idle(2);
        @(negedge clk);
        check("bare_end_err", err_cnt, 8'd2);

        // Backpressure and overwrite.
        @(posedge clk); #1 sample_ready = 1'b0;
        a = rand_sample();
        b = rand_sample();
        send_bytes(a, 14);
        pulse_end();
        idle(2);
        @(negedge clk);
        check("bp_valid_a", sample_valid, 1'b1);
        check("bp_ovr_a", overrun, 1'b0);
        last_exp = expect_of(b);
        sb.push_back(last_exp);
        send_bytes(b, 14);
        pulse_end();
        idle(3);
        @(negedge clk);
        check("bp_ovr_b", overrun, 1'b1);
        check("bp_valid_b", sample_valid, 1'b1);
        check("bp_ax_b", accel_x, last_exp.ax);
        idle(3);
        @(negedge clk);
        check("bp_hold", sample_valid, 1'b1);
        @(posedge clk); #1 sample_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release", sample_valid, 1'b0);
        check("bp_ovr_sticky", overrun, 1'b1);

        // Reset in the middle of a frame.
        send_bytes(rand_sample(), 6);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_err", err_cnt, 8'd0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_ax", accel_x, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        if (CAL) calibrate();
        send_good(rand_sample());
        @(negedge clk);
        check("mid_rst_err_after", err_cnt, 8'd0);

        idle(5);
        check("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
